// File: rtl/axi_rd_frame_gen_if.sv
// Bus bundle for the read frame generator: AXI AR/R channels, the frame
// interface toward the array read controller and the array return strobe.
interface axi_rd_frame_gen_if #(
  parameter int AXI_ADDR_WIDTH  = 20,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_FRAME_WIDTH = AXI_ADDR_WIDTH + AXI_DATA_WIDTH + 3
);
  logic                       axi_arvalid;
  logic                       axi_arready;
  logic [AXI_ADDR_WIDTH-1:0]  axi_araddr;
  logic [7:0]                 axi_arlen;
  logic                       axi_rvalid;
  logic                       axi_rready;
  logic [AXI_DATA_WIDTH-1:0]  axi_rdata;
  logic [1:0]                 axi_rresp;
  logic                       axi_rlast;
  logic [AXI_FRAME_WIDTH-1:0] axi_frame_rd_data;
  logic                       axi_frame_rd_valid;
  logic                       axi_frame_rd_ready;
  logic [AXI_DATA_WIDTH-1:0]  array_rd_rdata;
  logic                       array_rd_rvalid;

  modport slave (
    input  axi_arvalid, axi_araddr, axi_arlen, axi_rready,
           axi_frame_rd_ready, array_rd_rdata, array_rd_rvalid,
    output axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast,
           axi_frame_rd_data, axi_frame_rd_valid
  );

  modport master (
    output axi_arvalid, axi_araddr, axi_arlen, axi_rready,
           axi_frame_rd_ready, array_rd_rdata, array_rd_rvalid,
    input  axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast,
           axi_frame_rd_data, axi_frame_rd_valid
  );
endinterface

// File: rtl/axi_rd_frame_gen.sv
// Slices one AXI INCR read burst into row-bounded frames and returns the array
// data through a credit-protected show-ahead FIFO on the R channel.
module axi_rd_frame_gen #(
  parameter int AXI_ADDR_WIDTH  = 20,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_FRAME_WIDTH = AXI_ADDR_WIDTH + AXI_DATA_WIDTH + 3,
  parameter int AXI_RADDR_WIDTH = 14,
  parameter int AXI_CADDR_WIDTH = AXI_ADDR_WIDTH - AXI_RADDR_WIDTH,
  parameter int RFIFO_DEPTH     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  axi_rd_frame_gen_if.slave bus,
  output logic              rd_busy,
  output logic              rd_err_spurious
);
  localparam int AW = $clog2(RFIFO_DEPTH);
  localparam int SW = AW + 2;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]                 state;
  logic [AXI_ADDR_WIDTH-1:0]  cur_addr;
  logic [8:0]                 beats_left;
  logic [8:0]                 rcv_left;
  logic [8:0]                 r_left;
  logic                       first;
  logic [AW:0]                inflight;
  logic [AW:0]                cnt;
  logic [AW-1:0]              wr_ptr;
  logic [AW-1:0]              rd_ptr;
  logic [AXI_DATA_WIDTH-1:0]  mem [RFIFO_DEPTH];
  logic                       frame_valid;
  logic [AXI_FRAME_WIDTH-1:0] frame_data;

  logic                       ar_hs;
  logic                       fr_hs;
  logic                       push;
  logic                       pop;
  logic                       load;
  logic                       credit_ok;
  logic                       beat_eof;
  logic [8:0]                 len1;
  logic [SW-1:0]              reserved_nx;
  logic [AXI_RADDR_WIDTH-1:0] row;
  logic [AXI_CADDR_WIDTH-1:0] col;

  assign row      = cur_addr[AXI_ADDR_WIDTH-1 -: AXI_RADDR_WIDTH];
  assign col      = cur_addr[AXI_CADDR_WIDTH-1:0];
  assign len1     = {1'b0, bus.axi_arlen} + 9'd1;
  assign ar_hs    = (state == IDLE) && bus.axi_arvalid;
  assign fr_hs    = frame_valid && bus.axi_frame_rd_ready;
  assign push     = bus.array_rd_rvalid && (inflight != '0);
  assign pop      = (cnt != '0) && bus.axi_rready;
  assign beat_eof = (beats_left == 9'd1) || (&col);

  // Slots reserved after this edge: issued-but-unreturned words plus FIFO
  // occupancy. A new beat may only be presented if one slot is still free.
  assign reserved_nx = SW'(inflight) + SW'(cnt) + SW'(fr_hs) - SW'(pop);
  assign credit_ok   = reserved_nx < SW'(RFIFO_DEPTH);
  assign load        = (state == ISSUE) && (!frame_valid || fr_hs) &&
                       (beats_left != '0) && credit_ok;

  assign bus.axi_arready        = (state == IDLE);
  assign bus.axi_rvalid         = (cnt != '0);
  assign bus.axi_rdata          = mem[rd_ptr];
  assign bus.axi_rresp          = 2'b00;
  assign bus.axi_rlast          = (cnt != '0) && (r_left == 9'd1);
  assign bus.axi_frame_rd_valid = frame_valid;
  assign bus.axi_frame_rd_data  = frame_data;
  assign rd_busy                = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      cur_addr        <= '0;
      beats_left      <= '0;
      rcv_left        <= '0;
      r_left          <= '0;
      first           <= 1'b0;
      inflight        <= '0;
      cnt             <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      frame_valid     <= 1'b0;
      frame_data      <= '0;
      rd_err_spurious <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (bus.axi_arvalid) state <= ISSUE;
        ISSUE:   if (fr_hs && (beats_left == '0)) state <= DRAIN;
        DRAIN:   if ((rcv_left == '0) && (cnt == '0)) state <= IDLE;
        default: state <= IDLE;
      endcase

      // beats_left/cur_addr/first describe the next beat to be presented.
      if (ar_hs) begin
        cur_addr   <= bus.axi_araddr;
        beats_left <= len1;
        first      <= 1'b1;
      end else if (load) begin
        cur_addr   <= {row, col} + AXI_ADDR_WIDTH'(1);
        beats_left <= beats_left - 9'd1;
        first      <= beat_eof;
      end

      if (load) begin
        frame_valid <= 1'b1;
        frame_data  <= {first, beat_eof, 1'b0, cur_addr, {AXI_DATA_WIDTH{1'b0}}};
      end else if (fr_hs) begin
        frame_valid <= 1'b0;
      end

      if (ar_hs)     rcv_left <= len1;
      else if (push) rcv_left <= rcv_left - 9'd1;

      if (ar_hs)    r_left <= len1;
      else if (pop) r_left <= r_left - 9'd1;

      case ({fr_hs, push})
        2'b10:   inflight <= inflight + (AW+1)'(1);
        2'b01:   inflight <= inflight - (AW+1)'(1);
        default: inflight <= inflight;
      endcase

      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      if (bus.array_rd_rvalid && (inflight == '0)) rd_err_spurious <= 1'b1;
    end
  end

  // Return FIFO storage carries data only and needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.array_rd_rdata;
  end
endmodule

// File: doc/axi_rd_frame_gen.md
Name: axi_rd_frame_gen

Overview:
- Upstream/return stage of the array read controller.
- Accepts one AXI incremental read burst at a time.
- Slices the burst into sof/eof-delimited frames on the read frame interface; a row boundary forces a new frame and therefore a new activate.
- Collects the un-throttled array read data into a credit-protected FIFO and returns it on the AXI R channel with rlast.

Parameters:
- AXI_ADDR_WIDTH, 20, word address width.
- AXI_DATA_WIDTH, 64, data width.
- AXI_FRAME_WIDTH, AXI_ADDR_WIDTH+AXI_DATA_WIDTH+3, frame width.
- AXI_RADDR_WIDTH, 14, row address bits (upper address bits).
- AXI_CADDR_WIDTH, AXI_ADDR_WIDTH-AXI_RADDR_WIDTH, column address bits (lower address bits).
- RFIFO_DEPTH, 8, return FIFO depth; power of 2, minimum 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- axi_arvalid  in  1  read address valid.
- axi_arready  out  1  read address ready.
- axi_araddr  in  AXI_ADDR_WIDTH  start word address.
- axi_arlen  in  8  beats-1.
- axi_rvalid  out  1  read data valid.
- axi_rready  in  1  read data ready.
- axi_rdata  out  AXI_DATA_WIDTH  read data.
- axi_rresp  out  2  always 2'b00.
- axi_rlast  out  1  last beat of burst.
- axi_frame_rd_data  out  AXI_FRAME_WIDTH  frame to array read controller.
- axi_frame_rd_valid  out  1  frame valid.
- axi_frame_rd_ready  in  1  frame ready.
- array_rd_rdata  in  AXI_DATA_WIDTH  returned array data.
- array_rd_rvalid  in  1  returned data strobe, no backpressure.
- rd_busy  out  1  burst in progress.
- rd_err_spurious  out  1  sticky: data returned with no beat outstanding.

Behaviour:
- Single clock clk; rst_n synchronous, active-low. All registers reset on a clk edge with rst_n=0.
- Reset state:
  - state=IDLE; FIFO empty; counters 0.
  - axi_rvalid=0, axi_rlast=0, axi_frame_rd_valid=0, frame register all 0, rd_busy=0, rd_err_spurious=0.
- Reset mid-burst drops all state and FIFO contents; no further frames or R beats are produced.
- Frame format, MSB down:
  - sof at [FW-1], eof at [FW-2], cmd at [FW-3] (0=read), address at [AXI_DATA_WIDTH +: AXI_ADDR_WIDTH].
  - Column address is the low CADDR bits of the address field; row address is the upper bits.
  - Data field is always 0.
- FSM: IDLE, ISSUE, DRAIN.
  - IDLE: axi_arready=1 (combinational from state). On arvalid: latch cur_addr=araddr and beats_left=arlen+1 (9 bits, 1..256); set rcv_left=arlen+1; set first=1; go to ISSUE.
  - ISSUE: issues one frame beat per handshake (valid&ready). On the handshake of the beat with beats_left==1, go to DRAIN.
  - DRAIN: wait until rcv_left==0 and the FIFO is empty, then go to IDLE.
  - rd_busy = state != IDLE.
- Frame beat fields:
  - sof = first.
  - eof = (beats_left==1) OR (cur_addr column bits all 1).
  - After each handshake: cur_addr += 1, wrapping modulo 2^AXI_ADDR_WIDTH; beats_left -= 1; first = eof of the beat just sent.
  - A single-beat burst gives sof=eof=1. A row crossing splits the burst: the beat at column all-1s carries eof, the next beat carries sof.
- Frame valid and credit:
  - axi_frame_rd_valid is registered and asserts only when credit allows: inflight + fifo_count < RFIFO_DEPTH.
  - inflight = beats issued minus data words received.
  - Once asserted, valid and data hold stable until ready. The reserved credit cannot be lost because returns only free slots.
  - Valid deasserts the cycle after the final handshake unless the next beat is immediately eligible.
- Return path:
  - On array_rd_rvalid with inflight>0: push array_rd_rdata into the FIFO and decrement inflight and rcv_left.
  - Same cycle issue and return: inflight is unchanged.
  - array_rd_rvalid with inflight==0: data dropped, rd_err_spurious set to 1 until reset.
- R channel:
  - FIFO is show-ahead. axi_rvalid = ~empty; axi_rdata = FIFO head.
  - Pop on rvalid&rready. Simultaneous push and pop is legal at any fill level.
  - axi_rlast = rvalid AND the head word is the final word of the burst, tracked by an R beat counter loaded with arlen+1.
- Overflow is impossible by construction. Underflow is prevented by the rvalid gate.

Test Plan:
- araddr=0x00040, arlen=0, ready always 1 → one frame with sof=1, eof=1, cmd=0, addr=0x00040. Array returns 0xA5 → axi_rdata=0xA5 with rlast=1; then IDLE.
- araddr=0x0003E, arlen=3 (column width 6) → four beats:
  - addr 0x3E: sof=1, eof=0.
  - addr 0x3F: sof=0, eof=1.
  - addr 0x40: sof=1, eof=0.
  - addr 0x41: sof=0, eof=1.
  - Four R beats, rlast only on the 4th.
- arlen=15, array data withheld, frame ready=1 → exactly 8 beats issued, then valid low. Each returned word re-enables one further beat; 16 R beats delivered in order.
- axi_rready=0 for 20 cycles during arlen=15 → FIFO fills to 8, frame issue stalls, no data lost. Releasing rready yields 16 in-order beats.
- frame_rd_ready toggling 1-0-1 mid-beat → frame data and valid stable while ready=0, no duplicate or skipped addresses.
- array_rd_rvalid pulse in IDLE → rd_err_spurious=1, FIFO stays empty. Then rst_n=0 for 1 cycle during an active burst → all outputs return to their reset values, rd_err_spurious=0.
